// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage controller.
package wb_pkg;

  // Default distance from a jump's PC to its return address (covers the delay slot).
  localparam int unsigned LINK_OFFSET_DEFAULT = 8;

  // Register written by jump-and-link instructions.
  localparam logic [4:0] LINK_REG = 5'd31;

  // Write-back controller states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_MEM = 2'b01,
    ST_COMMIT   = 2'b10
  } wbState_e;

  // Load access size as presented by the memory stage.
  typedef enum logic [1:0] {
    LS_BYTE  = 2'b00,
    LS_HALF  = 2'b01,
    LS_WORD  = 2'b10,
    LS_DWORD = 2'b11
  } loadSize_e;

  // Clears the offset bits below the natural alignment of the access size.
  function automatic logic [2:0] alignOffset(input logic [1:0] size, input logic [2:0] off);
    logic [2:0] aligned;
    aligned = off;
    case (loadSize_e'(size))
      LS_BYTE:  aligned = off;
      LS_HALF:  aligned = {off[2:1], 1'b0};
      LS_WORD:  aligned = {off[2], 2'b00};
      LS_DWORD: aligned = 3'b000;
      default:  aligned = off;
    endcase
    return aligned;
  endfunction

endpackage

// File: rtl/wb_stage_ctrl_load_extract.sv
// Load data aligner and extender: picks the addressed bytes out of the memory
// word and widens them to a full register value.
module load_extract
  import wb_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [2:0]        byteOff_i,
  output logic [DATA_W-1:0] data_o
);

  logic [2:0]        offAligned;
  logic [DATA_W-1:0] shifted;

  // Move the addressed bytes down to bit 0 using the size-aligned offset.
  always_comb begin
    offAligned = alignOffset(size_i, byteOff_i);
    shifted    = rdata_i >> {offAligned, 3'b000};
  end

  // Zero- or sign-extend from the access width to the full register width.
  always_comb begin
    data_o = shifted;
    case (loadSize_e'(size_i))
      LS_BYTE:  data_o = {{(DATA_W-8){signed_i & shifted[7]}}, shifted[7:0]};
      LS_HALF:  data_o = {{(DATA_W-16){signed_i & shifted[15]}}, shifted[15:0]};
      LS_WORD:  data_o = {{(DATA_W-32){signed_i & shifted[31]}}, shifted[31:0]};
      LS_DWORD: data_o = shifted;
      default:  data_o = shifted;
    endcase
  end

endmodule

// File: rtl/wb_stage_ctrl.sv
// Write-back stage controller: accepts instructions from the memory stage,
// waits for load data when needed and issues one register-file write per
// instruction.
module wb_stage_ctrl
  import wb_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int PC_W        = 32,
  parameter int LINK_OFFSET = LINK_OFFSET_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [4:0]        ex_DstReg,
  input  logic [DATA_W-1:0] ex_AluResult,
  input  logic [PC_W-1:0]   ex_PC,
  input  logic              ex_RegWrite,
  input  logic              ex_MemToReg,
  input  logic              ex_JmpandLink,
  input  logic [1:0]        ex_LoadSize,
  input  logic              ex_LoadSigned,
  input  logic [2:0]        ex_ByteOff,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  output logic [4:0]        WB_DstReg,
  output logic [DATA_W-1:0] WB_Data,
  output logic              RegWrite,
  output logic              MEM_WB_JmpandLink,
  output logic              busy
);

  wbState_e state_q, state_d;

  // Values presented on the register-file write port.
  logic [4:0]        wbDst_q, wbDst_d;
  logic [DATA_W-1:0] wbData_q, wbData_d;
  logic              wbWe_q, wbWe_d;
  logic              wbLink_q, wbLink_d;

  // Fields of a load waiting for its memory data.
  logic [4:0]        pendDst_q, pendDst_d;
  logic              pendWe_q, pendWe_d;
  logic [1:0]        pendSize_q, pendSize_d;
  logic              pendSigned_q, pendSigned_d;
  logic [2:0]        pendOff_q, pendOff_d;

  logic              stageReady;
  logic              accept;
  logic [PC_W-1:0]   linkAddr;
  logic [DATA_W-1:0] loadData;

  // The stage takes new work whenever it is not stalled on a load; a flush
  // drops whatever is offered in that cycle.
  assign stageReady = (state_q != ST_WAIT_MEM);
  assign accept     = ex_valid && stageReady && !flush;
  assign linkAddr   = ex_PC + PC_W'(LINK_OFFSET);

  assign ex_ready          = rst_n && stageReady;
  assign busy              = (state_q == ST_WAIT_MEM);
  assign RegWrite          = (state_q == ST_COMMIT) && wbWe_q;
  assign MEM_WB_JmpandLink = (state_q == ST_COMMIT) && wbLink_q;
  assign WB_DstReg         = wbDst_q;
  assign WB_Data           = wbData_q;

  load_extract #(
    .DATA_W(DATA_W)
  ) u_load_extract (
    .rdata_i  (mem_rdata),
    .size_i   (pendSize_q),
    .signed_i (pendSigned_q),
    .byteOff_i(pendOff_q),
    .data_o   (loadData)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, write-port values and load capture for the coming cycle.
  always_comb begin
    state_d      = state_q;
    wbDst_d      = wbDst_q;
    wbData_d     = wbData_q;
    wbWe_d       = 1'b0;
    wbLink_d     = 1'b0;
    pendDst_d    = pendDst_q;
    pendWe_d     = pendWe_q;
    pendSize_d   = pendSize_q;
    pendSigned_d = pendSigned_q;
    pendOff_d    = pendOff_q;

    case (state_q)
      ST_WAIT_MEM: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mem_rvalid) begin
          state_d  = ST_COMMIT;
          wbDst_d  = pendDst_q;
          wbData_d = loadData;
          wbWe_d   = pendWe_q;
        end
      end
      default: begin
        if (!accept) begin
          state_d = ST_IDLE;
        end else if (ex_JmpandLink) begin
          state_d  = ST_COMMIT;
          wbDst_d  = LINK_REG;
          wbData_d = DATA_W'(linkAddr);
          wbWe_d   = ex_RegWrite;
          wbLink_d = 1'b1;
        end else if (ex_MemToReg) begin
          state_d      = ST_WAIT_MEM;
          pendDst_d    = ex_DstReg;
          pendWe_d     = ex_RegWrite && (ex_DstReg != 5'd0);
          pendSize_d   = ex_LoadSize;
          pendSigned_d = ex_LoadSigned;
          pendOff_d    = ex_ByteOff;
        end else begin
          state_d  = ST_COMMIT;
          wbDst_d  = ex_DstReg;
          wbData_d = ex_AluResult;
          wbWe_d   = ex_RegWrite && (ex_DstReg != 5'd0);
        end
      end
    endcase
  end

  // Write-port and pending-load registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbDst_q      <= '0;
      wbData_q     <= '0;
      wbWe_q       <= 1'b0;
      wbLink_q     <= 1'b0;
      pendDst_q    <= '0;
      pendWe_q     <= 1'b0;
      pendSize_q   <= '0;
      pendSigned_q <= 1'b0;
      pendOff_q    <= '0;
    end else begin
      wbDst_q      <= wbDst_d;
      wbData_q     <= wbData_d;
      wbWe_q       <= wbWe_d;
      wbLink_q     <= wbLink_d;
      pendDst_q    <= pendDst_d;
      pendWe_q     <= pendWe_d;
      pendSize_q   <= pendSize_d;
      pendSigned_q <= pendSigned_d;
      pendOff_q    <= pendOff_d;
    end
  end

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// Self-checking bench for wb_stage_ctrl: directed table, corner-case
// sequences and random traffic against a transaction-level model.
module tb_wb_stage_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_DstReg;
  logic [63:0] ex_AluResult;
  logic [31:0] ex_PC;
  logic        ex_RegWrite;
  logic        ex_MemToReg;
  logic        ex_JmpandLink;
  logic [1:0]  ex_LoadSize;
  logic        ex_LoadSigned;
  logic [2:0]  ex_ByteOff;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        flush;
  logic [4:0]  WB_DstReg;
  logic [63:0] WB_Data;
  logic        RegWrite;
  logic        MEM_WB_JmpandLink;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        valid;
    logic [4:0]  dst;
    logic [63:0] alu;
    logic [31:0] pc;
    logic        rw;
    logic        m2r;
    logic        jal;
    logic [1:0]  size;
    logic        sgn;
    logic [2:0]  off;
    logic        rvalid;
    logic [63:0] rdata;
    logic        flush;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        we;
    logic [4:0]  dst;
    logic [63:0] data;
    logic        link;
    logic        chkWb;
  } vec_t;

  // Reference model: what the write port should show in the current cycle,
  // plus whether a load is outstanding and its captured fields.
  logic        mWait;
  stim_t       mPend;
  logic        mWe;
  logic        mLink;
  logic [4:0]  mDst;
  logic [63:0] mData;

  wb_stage_ctrl #(
    .DATA_W(64),
    .PC_W(32),
    .LINK_OFFSET(8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid         (ex_valid),
    .ex_ready         (ex_ready),
    .ex_DstReg        (ex_DstReg),
    .ex_AluResult     (ex_AluResult),
    .ex_PC            (ex_PC),
    .ex_RegWrite      (ex_RegWrite),
    .ex_MemToReg      (ex_MemToReg),
    .ex_JmpandLink    (ex_JmpandLink),
    .ex_LoadSize      (ex_LoadSize),
    .ex_LoadSigned    (ex_LoadSigned),
    .ex_ByteOff       (ex_ByteOff),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .flush            (flush),
    .WB_DstReg        (WB_DstReg),
    .WB_Data          (WB_Data),
    .RegWrite         (RegWrite),
    .MEM_WB_JmpandLink(MEM_WB_JmpandLink),
    .busy             (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run never reaches its summary.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t idleStim();
    stim_t s;
    s.valid = 1'b0; s.dst = 5'd0; s.alu = 64'd0; s.pc = 32'd0;
    s.rw = 1'b0; s.m2r = 1'b0; s.jal = 1'b0; s.size = 2'd0; s.sgn = 1'b0;
    s.off = 3'd0; s.rvalid = 1'b0; s.rdata = 64'd0; s.flush = 1'b0;
    return s;
  endfunction

  function automatic stim_t aluOp(input logic [4:0] dst, input logic [63:0] alu, input logic rw);
    stim_t s;
    s = idleStim();
    s.valid = 1'b1; s.dst = dst; s.alu = alu; s.rw = rw;
    return s;
  endfunction

  function automatic stim_t jalOp(input logic [31:0] pc, input logic rw);
    stim_t s;
    s = idleStim();
    s.valid = 1'b1; s.jal = 1'b1; s.pc = pc; s.rw = rw; s.dst = 5'd7;
    return s;
  endfunction

  function automatic stim_t loadOp(input logic [4:0] dst, input logic [1:0] size,
                                   input logic sgn, input logic [2:0] off);
    stim_t s;
    s = idleStim();
    s.valid = 1'b1; s.m2r = 1'b1; s.rw = 1'b1; s.dst = dst;
    s.size = size; s.sgn = sgn; s.off = off;
    return s;
  endfunction

  function automatic vec_t makeVec(input stim_t s, input logic we, input logic [4:0] dst,
                                   input logic [63:0] data, input logic link, input logic chkWb);
    vec_t v;
    v.s = s; v.we = we; v.dst = dst; v.data = data; v.link = link; v.chkWb = chkWb;
    return v;
  endfunction

  // Load result from first principles: take 2^size bytes starting at the
  // offset rounded down to a multiple of the access size, then extend.
  function automatic logic [63:0] refLoad(input logic [63:0] rdata, input logic [1:0] size,
                                          input logic sgn, input logic [2:0] off);
    int          nBytes;
    int          start;
    logic [63:0] v;
    logic [63:0] mask;
    nBytes = 1 << size;
    start  = int'(off) - (int'(off) % nBytes);
    v      = rdata >> (8 * start);
    if (nBytes < 8) begin
      mask = (64'd1 << (8 * nBytes)) - 64'd1;
      v    = v & mask;
      if (sgn && v[8*nBytes-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic modelReset();
    mWait = 1'b0; mPend = idleStim(); mWe = 1'b0; mLink = 1'b0;
    mDst = 5'd0; mData = 64'd0;
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic modelAdvance(input stim_t s);
    mWe   = 1'b0;
    mLink = 1'b0;
    if (mWait) begin
      if (s.flush) begin
        mWait = 1'b0;
      end else if (s.rvalid) begin
        mWait = 1'b0;
        mWe   = mPend.rw && (mPend.dst != 5'd0);
        mDst  = mPend.dst;
        mData = refLoad(s.rdata, mPend.size, mPend.sgn, mPend.off);
      end
    end else if (s.valid && !s.flush) begin
      if (s.jal) begin
        mWe   = s.rw;
        mLink = 1'b1;
        mDst  = 5'd31;
        mData = {32'd0, s.pc + 32'd8};
      end else if (s.m2r) begin
        mWait = 1'b1;
        mPend = s;
      end else begin
        mWe   = s.rw && (s.dst != 5'd0);
        mDst  = s.dst;
        mData = s.alu;
      end
    end
  endtask

  task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, actual, required, $time);
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic checkOutput();
    checkValue("ex_ready", 64'(ex_ready), 64'(!mWait));
    checkValue("busy", 64'(busy), 64'(mWait));
    checkValue("RegWrite", 64'(RegWrite), 64'(mWe));
    checkValue("JmpandLink", 64'(MEM_WB_JmpandLink), 64'(mLink));
    checkValue("WB_DstReg", 64'(WB_DstReg), 64'(mDst));
    checkValue("WB_Data", WB_Data, mData);
  endtask

  task automatic setInputs(input stim_t s);
    ex_valid      = s.valid;
    ex_DstReg     = s.dst;
    ex_AluResult  = s.alu;
    ex_PC         = s.pc;
    ex_RegWrite   = s.rw;
    ex_MemToReg   = s.m2r;
    ex_JmpandLink = s.jal;
    ex_LoadSize   = s.size;
    ex_LoadSigned = s.sgn;
    ex_ByteOff    = s.off;
    mem_rvalid    = s.rvalid;
    mem_rdata     = s.rdata;
    flush         = s.flush;
  endtask

  // Drive one cycle of inputs, step the model, then check at the falling edge.
  task automatic applyStimulus(input stim_t s);
    setInputs(s);
    modelAdvance(s);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic checkAllZero(input string tag);
    checkValue({tag, "_ready"}, 64'(ex_ready), 64'd0);
    checkValue({tag, "_busy"}, 64'(busy), 64'd0);
    checkValue({tag, "_we"}, 64'(RegWrite), 64'd0);
    checkValue({tag, "_link"}, 64'(MEM_WB_JmpandLink), 64'd0);
    checkValue({tag, "_dst"}, 64'(WB_DstReg), 64'd0);
    checkValue({tag, "_data"}, WB_Data, 64'd0);
  endtask

  vec_t  tbl[8];
  stim_t s;
  int    busyCount;

  initial begin
    rst_n = 1'b0;
    setInputs(idleStim());
    modelReset();

    // Reset state while rst_n is held low.
    #1;
    checkAllZero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkValue("ready_after_reset", 64'(ex_ready), 64'd1);
    checkOutput();

    // Directed single-instruction table, each followed by an idle cycle.
    tbl[0] = makeVec(aluOp(5'd5, 64'h1234, 1'b1), 1'b1, 5'd5, 64'h1234, 1'b0, 1'b1);
    tbl[1] = makeVec(jalOp(32'h100, 1'b1), 1'b1, 5'd31, 64'h108, 1'b1, 1'b1);
    tbl[2] = makeVec(aluOp(5'd0, 64'hAAAA, 1'b1), 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tbl[3] = makeVec(aluOp(5'd7, 64'h77, 1'b0), 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    s = jalOp(32'h2000, 1'b1);
    s.m2r = 1'b1;
    tbl[4] = makeVec(s, 1'b1, 5'd31, 64'h2008, 1'b1, 1'b1);
    s = aluOp(5'd9, 64'h9999, 1'b1);
    s.flush = 1'b1;
    tbl[5] = makeVec(s, 1'b0, 5'd31, 64'h2008, 1'b0, 1'b1);
    tbl[6] = makeVec(aluOp(5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1), 1'b1, 5'd31,
                     64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    tbl[7] = makeVec(jalOp(32'hFFFF_FFF0, 1'b1), 1'b1, 5'd31, 64'h0000_0000_FFFF_FFF8, 1'b1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].s);
      checkValue($sformatf("tbl%0d_we", i), 64'(RegWrite), 64'(tbl[i].we));
      checkValue($sformatf("tbl%0d_link", i), 64'(MEM_WB_JmpandLink), 64'(tbl[i].link));
      if (tbl[i].chkWb) begin
        checkValue($sformatf("tbl%0d_dst", i), 64'(WB_DstReg), 64'(tbl[i].dst));
        checkValue($sformatf("tbl%0d_data", i), WB_Data, tbl[i].data);
      end
      applyStimulus(idleStim());
      checkValue($sformatf("tbl%0d_oneshot", i), 64'(RegWrite), 64'd0);
    end

    // Four back-to-back ALU ops give four consecutive single-cycle writes.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(aluOp(5'(10 + i), 64'(100 + i), 1'b1));
      checkValue($sformatf("b2b%0d_we", i), 64'(RegWrite), 64'd1);
      checkValue($sformatf("b2b%0d_dst", i), 64'(WB_DstReg), 64'(10 + i));
    end
    applyStimulus(idleStim());
    checkValue("b2b_end_we", 64'(RegWrite), 64'd0);

    // Signed byte load at offset 3 with data arriving in the third wait cycle.
    busyCount = 0;
    applyStimulus(loadOp(5'd4, 2'b00, 1'b1, 3'd3));
    if (busy && !ex_ready) busyCount++;
    repeat (2) begin
      applyStimulus(idleStim());
      if (busy && !ex_ready) busyCount++;
    end
    s = idleStim();
    s.rvalid = 1'b1;
    s.rdata  = 64'h0000_0000_80FF_0000;
    applyStimulus(s);
    checkValue("load_busy_cycles", 64'(busyCount), 64'd3);
    checkValue("load_we", 64'(RegWrite), 64'd1);
    checkValue("load_data", WB_Data, 64'hFFFF_FFFF_FFFF_FF80);
    applyStimulus(idleStim());

    // Flush together with load data: the flush wins and nothing is written.
    applyStimulus(loadOp(5'd6, 2'b10, 1'b0, 3'd4));
    s = idleStim();
    s.rvalid = 1'b1;
    s.rdata  = 64'h1122_3344_5566_7788;
    s.flush  = 1'b1;
    applyStimulus(s);
    checkValue("flush_load_we", 64'(RegWrite), 64'd0);
    checkValue("flush_load_idle", 64'(ex_ready && !busy), 64'd1);
    applyStimulus(idleStim());
    checkValue("flush_load_late_we", 64'(RegWrite), 64'd0);

    // Flush during COMMIT keeps the current write but drops the incoming op.
    applyStimulus(aluOp(5'd12, 64'hC0DE, 1'b1));
    s = aluOp(5'd13, 64'hBEEF, 1'b1);
    s.flush = 1'b1;
    setInputs(s);
    #1;
    checkValue("flush_commit_we", 64'(RegWrite), 64'd1);
    applyStimulus(s);
    checkValue("flush_commit_drop", 64'(RegWrite), 64'd0);

    // Load data arriving outside WAIT_MEM is ignored.
    s = idleStim();
    s.rvalid = 1'b1;
    s.rdata  = 64'hDEAD;
    applyStimulus(s);
    checkValue("stray_rvalid_we", 64'(RegWrite), 64'd0);

    // Reset in the middle of a pending load discards it.
    applyStimulus(loadOp(5'd8, 2'b11, 1'b0, 3'd0));
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("midload_reset");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    s = idleStim();
    s.rvalid = 1'b1;
    s.rdata  = 64'h55;
    applyStimulus(s);
    checkValue("midload_reset_we", 64'(RegWrite), 64'd0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      int kind;
      s = idleStim();
      kind     = int'($urandom_range(0, 3));
      s.valid  = ($urandom_range(0, 3) != 0);
      s.dst    = 5'($urandom_range(0, 31));
      s.alu    = {$urandom, $urandom};
      s.pc     = $urandom;
      s.rw     = ($urandom_range(0, 4) != 0);
      s.jal    = (kind == 0);
      s.m2r    = (kind <= 1);
      s.size   = 2'($urandom_range(0, 3));
      s.sgn    = 1'($urandom_range(0, 1));
      s.off    = 3'($urandom_range(0, 7));
      s.rvalid = ($urandom_range(0, 2) == 0);
      s.rdata  = {$urandom, $urandom};
      s.flush  = ($urandom_range(0, 15) == 0);
      applyStimulus(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage_ctrl.md
WB_STAGE_CTRL -- requirements
Module: wb_stage_ctrl

Interface
REQ-001 Parameter DATA_W, default 64: register write-data width.
REQ-002 Parameter PC_W, default 32: program-counter width.
REQ-003 Parameter LINK_OFFSET, default 8: link address = PC + LINK_OFFSET (delay slot).
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 ex_valid  in  1  upstream (MEM stage) presents an instruction.
REQ-008 ex_ready  out  1  stage can accept; transfer when ex_valid && ex_ready.
REQ-009 ex_DstReg  in  5  destination register.
REQ-010 ex_AluResult  in  DATA_W  ALU result.
REQ-011 ex_PC  in  PC_W  instruction PC.
REQ-012 ex_RegWrite, ex_MemToReg, ex_JmpandLink  in  1 each  control bits.
REQ-013 ex_LoadSize  in  2  00 byte, 01 half, 10 word, 11 dword.
REQ-014 ex_LoadSigned  in  1  sign-extend load result.
REQ-015 ex_ByteOff  in  3  byte offset of load within the 64-bit memory word.
REQ-016 mem_rvalid  in  1  load data valid; mem_rdata  in  DATA_W  load data.
REQ-017 flush  in  1  cancel pending/incoming instruction.
REQ-018 WB_DstReg  out  5; WB_Data  out  DATA_W; RegWrite  out  1; MEM_WB_JmpandLink  out  1  register-file write port.
REQ-019 busy  out  1  high in WAIT_MEM.

Function
REQ-020 States IDLE, WAIT_MEM, COMMIT; ex_ready = 1 in IDLE and COMMIT, 0 in WAIT_MEM.
REQ-021 Accept with ex_JmpandLink=1 -> COMMIT next cycle; WB_DstReg=31, WB_Data=zero-extended (ex_PC+LINK_OFFSET), MEM_WB_JmpandLink=1; ex_MemToReg ignored.
REQ-022 Accept with ex_MemToReg=1 (no link) -> WAIT_MEM; stay until mem_rvalid=1, then COMMIT next cycle with extracted load data.
REQ-023 Any other accept -> COMMIT next cycle with WB_Data=ex_AluResult.
REQ-024 Load extraction: mem_rdata shifted right by 8*ByteOff, ByteOff low bits forced to 0 per size alignment, then zero- or sign-extended from 8/16/32/64 bits.
REQ-025 RegWrite=1 only in COMMIT and only if captured ex_RegWrite=1 and (DstReg!=0 or link); exactly one cycle per instruction.
REQ-026 In COMMIT: new accept -> COMMIT or WAIT_MEM per REQ-021..023 (back-to-back, one write/cycle); no accept -> IDLE.
REQ-027 Non-load latency: write strobe 1 cycle after accept; load: 1 cycle after mem_rvalid.
REQ-028 mem_rvalid sampled only in WAIT_MEM; ignored elsewhere.
REQ-029 flush in WAIT_MEM -> IDLE, no write; flush with mem_rvalid same cycle: flush wins.
REQ-030 flush in any state blocks acceptance that cycle (instruction dropped); it does not suppress a write already in COMMIT.
REQ-031 WB_DstReg/WB_Data hold last committed values outside COMMIT.

Reset
REQ-032 rst_n low: state IDLE, all outputs 0 (ex_ready=1 after release), captured fields cleared; effective immediately, including mid-WAIT_MEM (pending load discarded).

Structure
REQ-033 Package wb_pkg: state enum, load-size encoding, LINK_OFFSET default.
REQ-034 One combinational sub-module load_extract (aligner + extender); FSM and capture registers in wb_stage_ctrl.

Verification
REQ-035 ALU op DstReg=5, AluResult=0x1234, RegWrite=1 -> next cycle RegWrite=1, WB_DstReg=5, WB_Data=0x1234, one cycle.
REQ-036 jal PC=0x100 -> next cycle WB_DstReg=31, WB_Data=0x108, MEM_WB_JmpandLink=1.
REQ-037 Signed byte load ByteOff=3, mem_rdata=0x00000000_80FF0000 after 3 wait cycles -> busy 3 cycles, ex_ready=0, then WB_Data=0xFFFF_FFFF_FFFF_FF80.
REQ-038 DstReg=0 ALU write -> RegWrite stays 0; back-to-back 4 ALU ops -> 4 consecutive single-cycle writes.
REQ-039 Load pending, flush asserted with mem_rvalid -> no write, state IDLE; rst_n low mid-WAIT_MEM -> outputs 0, no write after release.
